// File: rtl/product_combiner_if.sv
// Beat/result handshake bundle between the lane multipliers, the product combiner and the
// consumer.
interface product_combiner_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sew;
  logic        count_0;
  logic [15:0] pp1;
  logic [15:0] pp2;
  logic [15:0] pp3;
  logic [15:0] pp4;
  logic [15:0] pp5;
  logic [15:0] pp6;
  logic [15:0] pp7;
  logic [15:0] pp8;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [1:0]  out_sew;
  logic        err;

  modport master (
    output in_valid, sew, count_0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, out_ready,
    input  in_ready, out_valid, result, out_sew, err
  );

  modport slave (
    input  in_valid, sew, count_0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, out_ready,
    output in_ready, out_valid, result, out_sew, err
  );
endinterface

// File: rtl/product_combiner.sv
// Combines eight 8x8 lane products into 8-, 16- or 32-bit unsigned products; 32-bit
// products arrive as two half beats and are accumulated across them.
module product_combiner (
  input  logic               clk,
  input  logic               reset,
  product_combiner_if.slave  bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHalf = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [47:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;
  logic [1:0]  out_sew_q, out_sew_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;

  logic        accept;
  logic        load;
  logic [47:0] half_sum;
  logic [31:0] e0, e1;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_sew   = out_sew_q;
  assign bus.err       = err_q;

  // Lanes 1-4 weight the low B byte of the half, lanes 5-8 the next byte up.
  always_comb begin
    half_sum = 48'(bus.pp1)         + (48'(bus.pp5) << 8)
             + (48'(bus.pp2) << 8)  + (48'(bus.pp6) << 16)
             + (48'(bus.pp3) << 16) + (48'(bus.pp7) << 24)
             + (48'(bus.pp4) << 24) + (48'(bus.pp8) << 32);
    e0 = 32'(bus.pp1) + (32'(bus.pp2) << 8) + (32'(bus.pp5) << 8) + (32'(bus.pp6) << 16);
    e1 = 32'(bus.pp3) + (32'(bus.pp4) << 8) + (32'(bus.pp7) << 8) + (32'(bus.pp8) << 16);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    out_sew_d = out_sew_q;
    err_d     = err_q;
    load      = 1'b0;
    if (accept) begin
      unique case (bus.sew)
        2'b00, 2'b01: begin
          // A narrow beat abandons any pending half product.
          if (state_q == StHalf) err_d = 1'b1;
          result_d  = (bus.sew == 2'b00) ? {bus.pp4, bus.pp3, bus.pp2, bus.pp1} : {e1, e0};
          out_sew_d = bus.sew;
          load      = 1'b1;
          acc_d     = '0;
          state_d   = StIdle;
        end
        2'b10: begin
          if (state_q == StIdle) begin
            if (bus.count_0) err_d = 1'b1;
            acc_d   = half_sum;
            state_d = StHalf;
          end else begin
            if (!bus.count_0) err_d = 1'b1;
            result_d  = 64'(acc_q) + {half_sum, 16'b0};
            out_sew_d = 2'b10;
            load      = 1'b1;
            acc_d     = '0;
            state_d   = StIdle;
          end
        end
        default: begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
    out_valid_d = load || (out_valid_q && !bus.out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      result_q    <= '0;
      out_sew_q   <= 2'b00;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_sew_q   <= out_sew_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/product_combiner.md
PRODUCT_COMBINER -- requirements
Module: product_combiner

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  partial-product beat present.
REQ-004 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-005 SHALL have port sew  input  2  element width of beat: 00=8b, 01=16b, 10=32b, 11=illegal.
REQ-006 SHALL have port count_0  input  1  upstream phase flag: 0=B0/B1 half, 1=B2/B3 half (sew=10 only).
REQ-007 SHALL have ports pp1..pp8  input  16 each  unsigned 8x8 products from the eight lane multipliers (ppk = multk_A*multk_B).
REQ-008 SHALL have port out_valid  output  1  result holds a completed 64-bit product vector.
REQ-009 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-010 SHALL have port result  output  64  assembled unsigned products.
REQ-011 SHALL have port out_sew  output  2  sew of the beat that produced result.
REQ-012 SHALL have port err  output  1  sticky protocol-error flag, cleared only by reset.

Function
REQ-013 SHALL drive in_ready = !out_valid || out_ready (combinational); beats are ignored while in_ready=0.
REQ-014 SHALL implement FSM IDLE/HALF; IDLE on reset.
REQ-015 sew=00 beat (in IDLE): result <= {pp4,pp3,pp2,pp1}; out_valid asserts the following cycle (1-cycle latency).
REQ-016 sew=01 beat (in IDLE): e0 = pp1 + (pp2<<8) + (pp5<<8) + (pp6<<16); e1 = pp3 + (pp4<<8) + (pp7<<8) + (pp8<<16); each 32b, no truncation; result <= {e1,e0}; 1-cycle latency.
REQ-017 Half-sum for sew=10 SHALL be H = sum over i=0..3 of (pp(i+1)<<8i) + (pp(i+5)<<8(i+1)), computed in 48b without overflow.
REQ-018 sew=10 beat in IDLE: store H in 48b accumulator, go HALF, no output.
REQ-019 sew=10 beat in HALF: result <= acc + (H<<16) (64b); go IDLE; out_valid asserts the following cycle (2-beat, 1-cycle-after-last latency).
REQ-020 count_0 SHALL be checked, not used for sequencing: first beat expects 0, second expects 1; mismatch sets err, computation proceeds per FSM phase.
REQ-021 Non-10 beat accepted in HALF: discard accumulator, set err, process beat as fresh per REQ-015/016, go IDLE.
REQ-022 sew=11 beat: consumed, no output, err set, accumulator discarded, go IDLE.
REQ-023 result/out_sew SHALL hold stable while out_valid && !out_ready; out_valid deasserts after handshake unless a new result loads same edge (back-to-back allowed, full throughput).
REQ-024 Products are unsigned; no sign correction performed.

Reset
REQ-025 Reset SHALL asynchronously force: FSM=IDLE, accumulator=0, out_valid=0, result=0, out_sew=00, err=0; in_ready therefore 1.
REQ-026 Reset asserted in HALF SHALL drop the pending half; first post-reset sew=10 beat is a first half.

Verification
REQ-027 sew=00, A=0x04030201, B=0x05050505 products -> one cycle later out_valid=1, result=0x0014_000F_000A_0005.
REQ-028 sew=01, A=0x0002FFFF, B=0x0003FFFF -> result=0x00000006_FFFE0001, 1-cycle latency.
REQ-029 sew=10, A=B=0xFFFFFFFF, beats count_0=0 then 1 -> no out_valid after beat 1; result=0xFFFFFFFE00000001 one cycle after beat 2, err=0.
REQ-030 out_ready=0 with out_valid=1, new in_valid beat offered -> in_ready=0, result unchanged, beat not consumed; out_ready=1 -> drain, beat accepted next.
REQ-031 sew=10 first beat then sew=00 beat -> err=1, 8-bit result emitted, no 64b product emitted.
REQ-032 reset pulse while in HALF -> all outputs zero immediately; next sew=10 pair yields correct product.
